conv_ctrl: RTL and testbench

- Sequencing stage directly upstream of the pipelined MAC in the 2D convolution accelerator.
- Walks every valid output position of an R x R input over a K x K kernel and issues synchronous reads to the X and W memories.
- Streams the returned operand pairs into the MAC with correct init/valid timing and waits for the MAC pipeline to drain.
- Captures each accumulated result and presents it downstream on a valid/ready handshake.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_addr_gen.sv | 56 +++++
 rtl/conv_ctrl.sv | 83 ++++++++
 tb/tb_conv_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: sequencer state encoding and width helpers shared by the convolution control blocks
package conv_pkg;
  typedef enum logic [2:0] {IDLE, INIT, READ, DRAIN, OUTPUT, DONE} state_t;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int xaw(input int r);
    return cw(r * r);
  endfunction
  function automatic int waw(input int k);
    return cw(k * k);
  endfunction
  function automatic int nout(input int r, input int k);
    return (r - k + 1) * (r - k + 1);
  endfunction
endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: output-position and kernel-tap counters producing X/W read addresses without a multiplier
module conv_addr_gen import conv_pkg::*; #(
  parameter int R = 16,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tap_step,
  input  logic             pos_step,
  input  logic             tap_clr,
  output logic [xaw(R)-1:0] x_addr,
  output logic [waw(K)-1:0] w_addr,
  output logic             last_tap,
  output logic             last_pos
);
  localparam int XAW = xaw(R);
  localparam int PW = cw(R - K + 1);
  localparam int TW = cw(K);
  logic [PW-1:0] i, j;
  logic [TW-1:0] m, n;
  logic [XAW-1:0] base;
  logic n_end, j_end;
  assign n_end = n == TW'(K - 1);
  assign j_end = j == PW'(R - K);
  assign last_tap = n_end && (m == TW'(K - 1));
  assign last_pos = j_end && (i == PW'(R - K));
  // window origin i*R+j kept as a running sum; the final position wraps everything back to zero
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      i <= '0;
      j <= '0;
      base <= '0;
    end else if (pos_step) begin
      j <= j_end ? '0 : j + 1'b1;
      i <= last_pos ? '0 : j_end ? i + 1'b1 : i;
      base <= last_pos ? '0 : base + (j_end ? XAW'(K) : XAW'(1));
    end
  // tap walk inside the window; a row step skips R-K+1 X words, W is simply linear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      m <= '0;
      n <= '0;
      x_addr <= '0;
      w_addr <= '0;
    end else if (tap_clr) begin
      m <= '0;
      n <= '0;
      x_addr <= base;
      w_addr <= '0;
    end else if (tap_step) begin
      n <= n_end ? '0 : n + 1'b1;
      m <= n_end ? m + 1'b1 : m;
      x_addr <= x_addr + (n_end ? XAW'(R - K + 1) : XAW'(1));
      w_addr <= w_addr + 1'b1;
    end
endmodule

// File: rtl/conv_ctrl.sv
// conv_ctrl: sequences X/W reads into the pipelined MAC and hands each window result downstream
module conv_ctrl import conv_pkg::*; #(
  parameter int INW = 24,
  parameter int OUTW = 48,
  parameter int R = 16,
  parameter int K = 4,
  parameter int MAC_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [INW-1:0]    bias,
  output logic [xaw(R)-1:0] x_addr,
  output logic [waw(K)-1:0] w_addr,
  input  logic [INW-1:0]    x_data,
  input  logic [INW-1:0]    w_data,
  output logic [INW-1:0]    mac_input0,
  output logic [INW-1:0]    mac_input1,
  output logic [INW-1:0]    mac_init_value,
  output logic              mac_init_acc,
  output logic              mac_input_valid,
  input  logic [OUTW-1:0]   mac_out,
  output logic [OUTW-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam int DW = cw(MAC_LAT + 2);
  state_t state, nxt;
  logic [DW-1:0] dcnt;
  logic rd_q, last_tap, last_pos, drain_end, tap_step, pos_step, tap_clr;
  assign drain_end = (state == DRAIN) && (dcnt == DW'(MAC_LAT + 1));
  assign tap_step = (state == READ) && !last_tap;
  assign pos_step = (state == OUTPUT) && out_ready;
  assign tap_clr = state == INIT;
  assign mac_input0 = x_data;
  assign mac_input1 = w_data;
  assign mac_init_acc = state == INIT;
  assign mac_input_valid = rd_q;
  assign out_valid = state == OUTPUT;
  assign busy = state != IDLE;
  assign done = state == DONE;
  conv_addr_gen #(.R(R), .K(K)) u_addr (
    .clk(clk),
    .reset(reset),
    .tap_step(tap_step),
    .pos_step(pos_step),
    .tap_clr(tap_clr),
    .x_addr(x_addr),
    .w_addr(w_addr),
    .last_tap(last_tap),
    .last_pos(last_pos)
  );
  // next state; DRAIN is long enough that INIT never meets a product still in the MAC pipe
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? INIT : IDLE;
      INIT:    nxt = READ;
      READ:    nxt = last_tap ? DRAIN : READ;
      DRAIN:   nxt = drain_end ? OUTPUT : DRAIN;
      OUTPUT:  nxt = !out_ready ? OUTPUT : last_pos ? DONE : INIT;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state, read-issue delay matching the one-cycle memory latency, drain timer and result capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rd_q <= 1'b0;
      dcnt <= '0;
      mac_init_value <= '0;
      out_data <= '0;
    end else begin
      state <= nxt;
      rd_q <= state == READ;
      dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      if (nxt == INIT) mac_init_value <= bias;
      if (drain_end) out_data <= mac_out;
    end
endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: randomized bench with memory/MAC models and a window-sum reference for conv_ctrl
module tb_conv_ctrl;
  localparam int INW = 24, OUTW = 48, R = 16, K = 4, MAC_LAT = 4;
  localparam int P = R - K + 1, NO = P * P;
  localparam int XAW = $clog2(R * R), WAW = $clog2(K * K);

  logic clk = 0, reset = 1, start = 0, out_ready = 1;
  logic [INW-1:0] bias = '0;
  logic [XAW-1:0] x_addr;
  logic [WAW-1:0] w_addr;
  logic [INW-1:0] x_data = '0, w_data = '0, mac_input0, mac_input1, mac_init_value;
  logic mac_init_acc, mac_input_valid, out_valid, busy, done;
  logic [OUTW-1:0] mac_out, out_data;

  conv_ctrl #(.INW(INW), .OUTW(OUTW), .R(R), .K(K), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .bias(bias),
    .x_addr(x_addr), .w_addr(w_addr), .x_data(x_data), .w_data(w_data),
    .mac_input0(mac_input0), .mac_input1(mac_input1), .mac_init_value(mac_init_value),
    .mac_init_acc(mac_init_acc), .mac_input_valid(mac_input_valid), .mac_out(mac_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int xs[R*R];
  int ws[K*K];
  int bias_i;
  int total = 0, bad = 0;

  // synchronous-read memories
  always @(posedge clk) begin
    x_data <= INW'(xs[x_addr]);
    w_data <= INW'(ws[w_addr]);
  end

  function automatic logic [OUTW-1:0] sx(input logic [INW-1:0] v);
    return {{(OUTW-INW){v[INW-1]}}, v};
  endfunction

  // MAC: MAC_LAT-deep product pipe feeding a signed accumulator
  logic [OUTW-1:0] pp[MAC_LAT];
  logic pv[MAC_LAT];
  logic [OUTW-1:0] acc;
  assign mac_out = acc;
  always @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < MAC_LAT; s++) begin
        pp[s] <= '0;
        pv[s] <= 1'b0;
      end
      acc <= '0;
    end else begin
      pp[0] <= sx(mac_input0) * sx(mac_input1);
      pv[0] <= mac_input_valid;
      for (int s = 1; s < MAC_LAT; s++) begin
        pp[s] <= pp[s-1];
        pv[s] <= pv[s-1];
      end
      if (mac_init_acc) acc <= sx(mac_init_value);
      else if (pv[MAC_LAT-1]) acc <= acc + pp[MAC_LAT-1];
    end

  function automatic logic [OUTW-1:0] ref_val(input int p);
    longint s = longint'(bias_i);
    for (int m = 0; m < K; m++)
      for (int n = 0; n < K; n++)
        s += longint'(xs[(p / P + m) * R + p % P + n]) * longint'(ws[m * K + n]);
    return s[OUTW-1:0];
  endfunction

  function automatic int rnd24();
    logic [INW-1:0] t;
    t = INW'($urandom);
    return int'($signed(t));
  endfunction

  task automatic fill_ramp();
    for (int a = 0; a < R * R; a++) xs[a] = a;
    for (int a = 0; a < K * K; a++) ws[a] = 1;
    bias_i = 0;
  endtask

  task automatic fill_rand();
    for (int a = 0; a < R * R; a++) xs[a] = rnd24();
    for (int a = 0; a < K * K; a++) ws[a] = rnd24();
    bias_i = rnd24();
  endtask

  logic [OUTW-1:0] got[$];
  int vcnt[$];
  int hs[$];
  int first_cyc, dones, stall_chg;
  bit tmo;

  task automatic do_pass(input bit rnd, input int stall_idx, input int abort_after);
    int cyc = 0, mvc = 0, left = 10, tail = -1;
    logic [OUTW-1:0] sd = '0;
    logic [XAW-1:0] sa = '0;
    got.delete();
    vcnt.delete();
    hs.delete();
    first_cyc = -1;
    dones = 0;
    stall_chg = 0;
    tmo = 0;
    bias = INW'(bias_i);
    @(negedge clk);
    start = 1;
    out_ready = 1;
    @(posedge clk);
    #1 start = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        tmo = 1;
        break;
      end
      if (mac_input_valid) mvc++;
      if (done) begin
        dones++;
        break;
      end
      if (tail > 0) begin
        tail--;
        if (tail == 0) break;
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (got.size() == stall_idx && left > 0 && (out_valid || left < 10)) begin
        if (left == 10) begin
          sd = out_data;
          sa = x_addr;
        end else if (!out_valid || out_data !== sd || x_addr !== sa || mac_input_valid) stall_chg++;
        left--;
        out_ready = 0;
      end else out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        vcnt.push_back(mvc);
        hs.push_back(cyc);
        mvc = 0;
        if (got.size() == abort_after) tail = 5;
      end
    end
    out_ready = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, out_valid, done, mac_init_acc, mac_input_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got %b exp 00000", {busy, out_valid, done, mac_init_acc, mac_input_valid});
    end
    total++;
    if (out_data !== '0 || mac_init_value !== '0) begin
      bad++;
      $display("FAIL reset_data got out=%0h init=%0h exp 0", out_data, mac_init_value);
    end
    total++;
    if (x_addr !== '0 || w_addr !== '0) begin
      bad++;
      $display("FAIL reset_addr got x=%0d w=%0d exp 0", x_addr, w_addr);
    end
    reset = 0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start got busy=%b exp 0", busy);
    end
  endtask

  task automatic check_seq(input string nm);
    total++;
    if (tmo || got.size() != NO) begin
      bad++;
      $display("FAIL %s_count got %0d timeout=%0d exp %0d", nm, got.size(), tmo, NO);
    end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if (got[k] !== ref_val(k)) begin
        bad++;
        $display("FAIL %s_out[%0d] got %0d exp %0d", nm, k, $signed(got[k]), $signed(ref_val(k)));
      end
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL %s_done got %0d pulses exp 1", nm, dones);
    end
  endtask

  task automatic test_ramp();
    fill_ramp();
    do_pass(0, -1, -1);
    check_seq("ramp");
    total++;
    if (got.size() > 0 && got[0] !== OUTW'(408)) begin
      bad++;
      $display("FAIL ramp_first got %0d exp 408", got[0]);
    end
    total++;
    if (got.size() == NO && got[NO-1] !== OUTW'(3672)) begin
      bad++;
      $display("FAIL ramp_last got %0d exp 3672", got[NO-1]);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL post_done got done=%b busy=%b exp 0 0", done, busy);
      end
    end
  endtask

  task automatic test_bias();
    fill_ramp();
    bias_i = -100;
    do_pass(0, -1, -1);
    check_seq("bias");
    total++;
    if (got.size() > 0 && got[0] !== OUTW'(308)) begin
      bad++;
      $display("FAIL bias_first got %0d exp 308", $signed(got[0]));
    end
  endtask

  task automatic test_latency();
    fill_rand();
    do_pass(0, -1, -1);
    check_seq("lat");
    total++;
    if (first_cyc != 24) begin
      bad++;
      $display("FAIL first_valid got cycle %0d exp 24", first_cyc);
    end
    for (int k = 0; k < vcnt.size(); k++) begin
      total++;
      if (vcnt[k] != K * K) begin
        bad++;
        $display("FAIL valid_cnt[%0d] got %0d exp %0d", k, vcnt[k], K * K);
      end
    end
    for (int k = 1; k < hs.size(); k++) begin
      total++;
      if (hs[k] - hs[k-1] != 24) begin
        bad++;
        $display("FAIL period[%0d] got %0d exp 24", k, hs[k] - hs[k-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_rand();
    do_pass(1, -1, -1);
    check_seq("bp");
  endtask

  task automatic test_stall();
    fill_rand();
    do_pass(0, 3, -1);
    check_seq("stall");
    total++;
    if (stall_chg != 0) begin
      bad++;
      $display("FAIL stall_hold got %0d changes exp 0", stall_chg);
    end
    total++;
    if (hs.size() > 3 && hs[3] - hs[2] != 34) begin
      bad++;
      $display("FAIL stall_period got %0d exp 34", hs[3] - hs[2]);
    end
  endtask

  task automatic test_max();
    longint mx;
    for (int a = 0; a < R * R; a++) xs[a] = 32'h7FFFFF;
    for (int a = 0; a < K * K; a++) ws[a] = 32'h7FFFFF;
    bias_i = 0;
    mx = longint'(K * K) * 64'sd8388607 * 64'sd8388607;
    do_pass(0, -1, -1);
    check_seq("max");
    for (int k = 0; k < got.size(); k += 40) begin
      total++;
      if (got[k] !== mx[OUTW-1:0]) begin
        bad++;
        $display("FAIL max_out[%0d] got %0h exp %0h", k, got[k], mx[OUTW-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_ramp();
    do_pass(0, -1, 2);
    total++;
    if (busy !== 1'b1 || got.size() != 2 || x_addr === '0) begin
      bad++;
      $display("FAIL pre_abort got busy=%b outs=%0d x=%0d exp 1 2 nonzero", busy, got.size(), x_addr);
    end
    #2 reset = 1;
    #1;
    total++;
    if ({busy, out_valid, done, mac_init_acc, mac_input_valid} !== 5'b0) begin
      bad++;
      $display("FAIL abort_flags got %b exp 00000", {busy, out_valid, done, mac_init_acc, mac_input_valid});
    end
    total++;
    if (out_data !== '0 || x_addr !== '0 || w_addr !== '0 || mac_init_value !== '0) begin
      bad++;
      $display("FAIL abort_data got out=%0h x=%0d w=%0d init=%0h exp 0", out_data, x_addr, w_addr, mac_init_value);
    end
    repeat (2) @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL abort_done got %b exp 0", done);
    end
    reset = 0;
    fill_rand();
    do_pass(0, -1, -1);
    check_seq("rerun");
  endtask

  initial begin
    fill_ramp();
    test_reset();
    test_ramp();
    test_bias();
    test_latency();
    test_backpressure();
    test_stall();
    test_max();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
